// File: rtl/ctrl_pipeline_pkg.sv
// Shared opcodes, control encodings and stage-control structs for the
// in-order pipeline control block.
package ctrl_pipeline_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_ADDI = 8'h10;
    localparam logic [7:0] OP_LW   = 8'h20;
    localparam logic [7:0] OP_SW   = 8'h21;
    localparam logic [7:0] OP_BEQ  = 8'h30;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_CMP  = 4'd3;

    localparam logic [1:0] SRC_REG = 2'b00;
    localparam logic [1:0] SRC_IMM = 2'b01;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] alu_src;
        logic       rb_select;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    // Later stages only carry the fields they still consume.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       reg_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic [1:0] mem_to_reg;
        logic       reg_write;
    } wb_ctrl_t;

    function automatic logic is_branch(input ctrl_t c);
        return c.alu_op == ALU_CMP;
    endfunction

    function automatic mem_ctrl_t to_mem(input ctrl_t c);
        return '{mem_read: c.mem_read, mem_write: c.mem_write,
                 mem_to_reg: c.mem_to_reg, reg_write: c.reg_write};
    endfunction

    function automatic wb_ctrl_t to_wb(input mem_ctrl_t c);
        return '{mem_to_reg: c.mem_to_reg, reg_write: c.reg_write};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder; unknown opcodes decode to an all-zero NOP.
module ctrl_decode
    import ctrl_pipeline_pkg::*;
#(
    parameter int OP_W = 8
) (
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (op)
            OP_W'(OP_ADD): begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.rb_select = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_W'(OP_SUB): begin
                ctrl.alu_op    = ALU_SUB;
                ctrl.rb_select = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_W'(OP_ADDI): begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = SRC_IMM;
                ctrl.reg_write = 1'b1;
            end
            OP_W'(OP_LW): begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = SRC_IMM;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = M2R_MEM;
                ctrl.reg_write  = 1'b1;
            end
            OP_W'(OP_SW): begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = SRC_IMM;
                ctrl.rb_select = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_W'(OP_BEQ): begin
                ctrl.alu_op    = ALU_CMP;
                ctrl.rb_select = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Pipeline control: ID decode, EX/MEM/WB control registers, hazard
// stalls, branch flush, multi-cycle memory freeze and operand forwarding.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
#(
    parameter int OP_W    = 8,
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_op,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              branch_taken,
    output logic              stall_if,
    output logic              flush_id,
    output logic              ex_valid,
    output logic [3:0]        ex_alu_op,
    output logic [1:0]        ex_alu_src,
    output logic              ex_rb_select,
    output logic              mem_valid,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_valid,
    output logic [1:0]        wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

    ctrl_t             id_ctrl;
    logic              vld_p0, vld_p1, vld_p2;
    ctrl_t             ctrl_p0;
    mem_ctrl_t         mctl_p1;
    wb_ctrl_t          wctl_p2;
    logic [REG_AW-1:0] ra_p0, rb_p0, rd_p0, rd_p1, rd_p2;
    logic [1:0]        lat_cnt;
    logic              freeze, flush, load_use, bubble;
    logic              mem_wr_ok, wb_wr_ok;

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .op   (id_op),
        .ctrl (id_ctrl)
    );

    // Hazard resolution, highest priority first.
    always_comb begin
        freeze   = vld_p1 && (mctl_p1.mem_read || mctl_p1.mem_write) && (lat_cnt < CNT_LAST);
        flush    = !freeze && vld_p0 && is_branch(ctrl_p0) && branch_taken;
        load_use = !freeze && !flush && id_valid && vld_p0 && ctrl_p0.mem_read &&
                   (rd_p0 != '0) &&
                   ((rd_p0 == id_ra) || (id_ctrl.rb_select && (rd_p0 == id_rb)));
        bubble   = flush || load_use;
    end

    // ID -> EX (p0) -> MEM (p1) -> WB (p2)
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            ctrl_p0 <= '0;
            mctl_p1 <= '0;
            wctl_p2 <= '0;
            ra_p0   <= '0;
            rb_p0   <= '0;
            rd_p0   <= '0;
            rd_p1   <= '0;
            rd_p2   <= '0;
            lat_cnt <= '0;
        end else if (freeze) begin
            vld_p2  <= 1'b0;
            wctl_p2 <= '0;
            lat_cnt <= lat_cnt + 2'd1;
        end else begin
            lat_cnt <= '0;
            vld_p0  <= id_valid && !bubble;
            ctrl_p0 <= (id_valid && !bubble) ? id_ctrl : '0;
            ra_p0   <= id_ra;
            rb_p0   <= id_rb;
            rd_p0   <= id_rd;
            vld_p1  <= vld_p0;
            mctl_p1 <= to_mem(ctrl_p0);
            rd_p1   <= rd_p0;
            vld_p2  <= vld_p1;
            wctl_p2 <= to_wb(mctl_p1);
            rd_p2   <= rd_p1;
        end
    end

    assign stall_if = freeze || load_use;
    assign flush_id = flush;

    assign ex_valid      = vld_p0;
    assign ex_alu_op     = vld_p0 ? ctrl_p0.alu_op    : '0;
    assign ex_alu_src    = vld_p0 ? ctrl_p0.alu_src   : '0;
    assign ex_rb_select  = vld_p0 && ctrl_p0.rb_select;
    assign mem_valid     = vld_p1;
    assign mem_read      = vld_p1 && mctl_p1.mem_read;
    assign mem_write     = vld_p1 && mctl_p1.mem_write;
    assign wb_valid      = vld_p2;
    assign wb_mem_to_reg = vld_p2 ? wctl_p2.mem_to_reg : '0;
    assign wb_reg_write  = vld_p2 && wctl_p2.reg_write;
    assign wb_rd         = vld_p2 ? rd_p2 : '0;

    // Loads in MEM have no data yet, so they never forward from MEM.
    assign mem_wr_ok = vld_p1 && mctl_p1.reg_write && !mctl_p1.mem_read && (rd_p1 != '0);
    assign wb_wr_ok  = vld_p2 && wctl_p2.reg_write && (rd_p2 != '0);

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (vld_p0) begin
            if (mem_wr_ok && (rd_p1 == ra_p0))     fwd_a = FWD_MEM;
            else if (wb_wr_ok && (rd_p2 == ra_p0)) fwd_a = FWD_WB;
            if (mem_wr_ok && (rd_p1 == rb_p0))     fwd_b = FWD_MEM;
            else if (wb_wr_ok && (rd_p2 == rb_p0)) fwd_b = FWD_WB;
        end
    end

endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 SHALL have parameter OP_W, default 8, meaning opcode width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register index width; register 0 is hardwired zero.
REQ-003 SHALL have parameter MEM_LAT, default 1, legal 1..4, meaning cycles one load/store occupies MEM.
REQ-004 SHALL have ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds an instruction.
- id_op  in  OP_W  ID opcode.
- id_ra, id_rb, id_rd  in  REG_AW  ID source/destination indices.
- branch_taken  in  1  EX branch resolved taken; ignored unless EX holds valid BEQ.
- stall_if  out  1  hold PC and IF/ID register.
- flush_id  out  1  squash IF/ID register.
- ex_valid, ex_alu_op[3:0], ex_alu_src[1:0], ex_rb_select  out  EX-stage controls.
- mem_valid, mem_read, mem_write  out  MEM-stage controls.
- wb_valid, wb_mem_to_reg[1:0], wb_reg_write, wb_rd[REG_AW]  out  WB-stage controls.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 from MEM, 10 from WB.

Function
REQ-005 SHALL decode id_op combinationally: NOP 0x00, ADD 0x01, SUB 0x02, ADDI 0x10, LW 0x20, SW 0x21, BEQ 0x30; any other opcode decodes as NOP (all controls 0, reg_write 0).
REQ-006 SHALL register decoded controls, ra, rb, rd through ID->EX->MEM->WB, one stage per unfrozen cycle, each stage with its own valid bit; all control outputs are gated by their stage valid.
REQ-007 SHALL assert a memory freeze while mem_valid and (mem_read or mem_write) and an internal counter < MEM_LAT-1; during freeze: stall_if=1, ID/EX/MEM hold, WB receives a bubble; counter increments per frozen cycle and clears when MEM advances.
REQ-008 SHALL, with MEM_LAT=1, never freeze.
REQ-009 SHALL, when EX holds valid BEQ and branch_taken=1 (not frozen): flush_id=1 and EX receives a bubble next cycle; load-use stall is suppressed that cycle.
REQ-010 SHALL detect load-use when id_valid, EX valid with mem_read, ex_rd!=0, and ex_rd equals id_ra, or equals id_rb for ADD/SUB/SW/BEQ: stall_if=1 for exactly one cycle, ID holds, EX receives a bubble.
REQ-011 SHALL apply priority: reset > memory freeze > branch flush > load-use stall > normal advance.
REQ-012 SHALL compute fwd_a combinationally: 01 if mem_valid, MEM reg_write, MEM not load, mem_rd!=0, mem_rd==ex_ra; else 10 if wb_valid, wb_reg_write, wb_rd!=0, wb_rd==ex_ra; else 00; fwd_b identically against ex_rb.
REQ-013 SHALL drive fwd_a=fwd_b=00 when ex_valid=0.
REQ-014 SHALL deassert stall_if and flush_id in every cycle where no condition of REQ-007/009/010 holds.

Reset
REQ-015 SHALL, on a clock edge with reset=1, clear all stage valid bits, all registered controls and indices, and the freeze counter to 0.
REQ-016 SHALL drive all outputs 0 in the cycle after reset, including when reset arrives mid-freeze or mid-stall.

Structure
REQ-017 SHALL place opcode constants, the stage-control struct (alu_op, alu_src, rb_select, mem_read, mem_write, mem_to_reg, reg_write) and fwd encodings in package ctrl_pipeline_pkg.
REQ-018 SHALL implement decoding in one sub-module ctrl_decode (purely combinational, opcode -> control struct).

Verification
REQ-019 Bench SHALL cover: LW rd=3 then ADD ra=3 back-to-back -> stall_if=1 one cycle, bubble in EX, then fwd_a=10 when ADD reaches EX.
REQ-020 Bench SHALL cover: ADD rd=4 then SUB ra=4 rb=4 -> no stall, fwd_a=fwd_b=01 in SUB's EX cycle.
REQ-021 Bench SHALL cover: BEQ in EX with branch_taken=1 while LW-use pattern in ID -> flush_id=1, stall_if=0, next ex_valid=0.
REQ-022 Bench SHALL cover: MEM_LAT=3, SW in MEM -> stall_if=1 for 2 cycles, wb_valid=0 for 2 cycles, then SW advances.
REQ-023 Bench SHALL cover: write to rd=0 followed by use of r0 -> no stall, fwd=00; opcode 0xFF -> behaves as NOP.
REQ-024 Bench SHALL cover: reset asserted during MEM_LAT freeze -> next cycle all outputs 0, counter restarts on next load.
